// File: rtl/y_window_acc.sv
// Windowed accumulator for the demo product stream: sums, peaks and counts
// windows of 2^N_LOG2 samples; a sel change flushes a partial window.
module y_window_acc #(
   parameter int unsigned DW     = 16,
   parameter int unsigned N_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   input  logic                 sel,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [DW+N_LOG2-1:0] out_sum,
   output logic [DW-1:0]        out_max,
   output logic [N_LOG2:0]      out_count,
   output logic                 out_partial,
   output logic                 overrun
);

   localparam int unsigned SW = DW + N_LOG2;
   localparam int unsigned CW = N_LOG2 + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << N_LOG2) - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(1 << N_LOG2);

   // window state; EMPTY/FILLING is implied by cnt
   logic [SW-1:0] acc;
   logic [DW-1:0] pk;
   logic [CW-1:0] cnt;
   logic          sel_q;

   logic [SW-1:0] acc_d;
   logic [DW-1:0] pk_d;
   logic [CW-1:0] cnt_d;

   logic          sel_chg;
   logic          flush;
   logic          complete;
   logic          load;
   logic [SW-1:0] sum_in;
   logic [DW-1:0] max_in;

   logic [SW-1:0] ld_sum;
   logic [DW-1:0] ld_max;
   logic [CW-1:0] ld_cnt;
   logic          ld_partial;
   logic          out_valid_d;
   logic          overrun_d;

   // next-state and output-register load selection
   always_comb begin
      sel_chg     = (sel != sel_q);
      flush       = sel_chg && (cnt != '0);
      complete    = in_valid && !flush && (cnt == CNT_LAST);
      load        = flush || complete;
      sum_in      = acc + SW'(in_data);
      max_in      = (in_data > pk) ? in_data : pk;

      acc_d       = acc;
      pk_d        = pk;
      cnt_d       = cnt;
      ld_sum      = sum_in;
      ld_max      = max_in;
      ld_cnt      = CNT_FULL;
      ld_partial  = 1'b0;

      if (flush) begin
         // a same-cycle sample opens the new window
         ld_sum     = acc;
         ld_max     = pk;
         ld_cnt     = cnt;
         ld_partial = 1'b1;
         if (in_valid) begin
            acc_d = SW'(in_data);
            pk_d  = in_data;
            cnt_d = CW'(1);
         end else begin
            acc_d = '0;
            pk_d  = '0;
            cnt_d = '0;
         end
      end else if (complete) begin
         acc_d = '0;
         pk_d  = '0;
         cnt_d = '0;
      end else if (in_valid) begin
         acc_d = sum_in;
         pk_d  = max_in;
         cnt_d = cnt + CW'(1);
      end

      out_valid_d = load || (out_valid && !out_ready);
      overrun_d   = overrun || (load && out_valid && !out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         pk    <= '0;
         cnt   <= '0;
         sel_q <= 1'b0;
      end else begin
         acc   <= acc_d;
         pk    <= pk_d;
         cnt   <= cnt_d;
         sel_q <= sel;
      end
   end

   // one-entry output register; data only changes on load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_max     <= '0;
         out_count   <= '0;
         out_partial <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         out_valid <= out_valid_d;
         overrun   <= overrun_d;
         if (load) begin
            out_sum     <= ld_sum;
            out_max     <= ld_max;
            out_count   <= ld_cnt;
            out_partial <= ld_partial;
         end
      end
   end

endmodule

// File: tb/tb_y_window_acc.sv
// Self-checking bench for y_window_acc: directed scenarios plus random traffic
// compared against a window/queue level reference model.
module tb_y_window_acc;

   localparam int unsigned DW     = 16;
   localparam int unsigned N_LOG2 = 4;
   localparam int unsigned N      = 1 << N_LOG2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic              sel = 1'b0;
   logic              out_ready = 1'b1;
   logic              out_valid;
   logic [DW+N_LOG2-1:0] out_sum;
   logic [DW-1:0]     out_max;
   logic [N_LOG2:0]   out_count;
   logic              out_partial;
   logic              overrun;

   y_window_acc #(.DW(DW), .N_LOG2(N_LOG2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel),
      .out_ready(out_ready), .out_valid(out_valid), .out_sum(out_sum),
      .out_max(out_max), .out_count(out_count), .out_partial(out_partial),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW+N_LOG2-1:0] sum;
      logic [DW-1:0]        mx;
      logic [N_LOG2:0]      cnt;
      logic                 part;
   } res_t;

   // reference model: samples of the open window, unconsumed results
   int unsigned win[$];
   res_t        exp_q[$];
   logic        msel;
   logic        e_ovr;
   logic        cur_sel;

   int n_pass  = 0;
   int n_total = 0;

   function automatic void close_window(input logic part);
      res_t r;
      int unsigned s = 0;
      int unsigned m = 0;
      foreach (win[i]) begin
         s += win[i];
         if (win[i] > m) m = win[i];
      end
      r.sum  = (DW+N_LOG2)'(s);
      r.mx   = DW'(m);
      r.cnt  = (N_LOG2+1)'(win.size());
      r.part = part;
      if (exp_q.size() != 0) begin
         e_ovr = 1'b1;
         exp_q.delete();
      end
      exp_q.push_back(r);
      win.delete();
   endfunction

   function automatic void model_step(input logic v, input logic [DW-1:0] d,
                                      input logic s, input logic r);
      if (r && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s != msel && win.size() != 0) close_window(1'b1);
      if (v) begin
         win.push_back(int'(d));
         if (win.size() == N) close_window(1'b0);
      end
      msel = s;
   endfunction

   task automatic tick(input logic v, input logic [DW-1:0] d, input logic s, input logic r);
      in_valid  = v;
      in_data   = d;
      sel       = s;
      out_ready = r;
      @(posedge clk);
      model_step(v, d, s, r);
      #1;
   endtask

   task automatic test_reset(input logic s_hold);
      rst      = 1'b1;
      in_valid = 1'b0;
      sel      = s_hold;
      cur_sel  = s_hold;
      #2;
      win.delete();
      exp_q.delete();
      msel  = 1'b0;
      e_ovr = 1'b0;
      n_total++;
      if ({out_valid, out_sum, out_max, out_count, out_partial, overrun} !== '0) begin
         $display("FAIL reset_outputs got v=%0b sum=%h max=%h cnt=%0d p=%0b ovr=%0b required all 0",
                  out_valid, out_sum, out_max, out_count, out_partial, overrun);
      end else n_pass++;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
   endtask

   task automatic test_const;
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, 16'h0100, cur_sel, 1'b1);
         n_total++;
         if (out_valid !== (exp_q.size() != 0)) begin
            $display("FAIL const_valid i=%0d got %0b required %0b", i, out_valid, exp_q.size() != 0);
         end else n_pass++;
      end
      n_total++;
      if ({out_valid, out_sum, out_max, out_count, out_partial} !== {1'b1, 20'h01000, 16'h0100, 5'd16, 1'b0}) begin
         $display("FAIL const_result got v=%0b sum=%h max=%h cnt=%0d p=%0b required v=1 sum=01000 max=0100 cnt=16 p=0",
                  out_valid, out_sum, out_max, out_count, out_partial);
      end else n_pass++;
      tick(1'b0, '0, cur_sel, 1'b1);
      n_total++;
      if (out_valid !== 1'b0) begin
         $display("FAIL const_drop got out_valid=%0b required 0", out_valid);
      end else n_pass++;
   endtask

   task automatic test_extremes;
      for (int i = 0; i < 32; i++) begin
         tick(1'b1, (i < 16) ? 16'hFFFF : DW'(i - 15), cur_sel, 1'b1);
         n_total++;
         if (out_valid !== (exp_q.size() != 0)) begin
            $display("FAIL extreme_valid i=%0d got %0b required %0b", i, out_valid, exp_q.size() != 0);
         end else n_pass++;
         if (i == 15) begin
            n_total++;
            if ({out_sum, out_max, out_count} !== {20'hFFFF0, 16'hFFFF, 5'd16}) begin
               $display("FAIL extreme_max got sum=%h max=%h cnt=%0d required sum=ffff0 max=ffff cnt=16",
                        out_sum, out_max, out_count);
            end else n_pass++;
         end
      end
      n_total++;
      if ({out_sum, out_max, out_count, out_partial} !== {20'd136, 16'd16, 5'd16, 1'b0}) begin
         $display("FAIL extreme_ramp got sum=%0d max=%0d cnt=%0d p=%0b required sum=136 max=16 cnt=16 p=0",
                  out_sum, out_max, out_count, out_partial);
      end else n_pass++;
   endtask

   task automatic test_partial;
      for (int i = 1; i <= 5; i++) tick(1'b1, DW'(i), cur_sel, 1'b1);
      cur_sel = ~cur_sel;
      tick(1'b1, 16'd7, cur_sel, 1'b1);
      n_total++;
      if ({out_valid, out_sum, out_max, out_count, out_partial} !== {1'b1, 20'd15, 16'd5, 5'd5, 1'b1}) begin
         $display("FAIL partial_flush got v=%0b sum=%0d max=%0d cnt=%0d p=%0b required v=1 sum=15 max=5 cnt=5 p=1",
                  out_valid, out_sum, out_max, out_count, out_partial);
      end else n_pass++;
      for (int i = 0; i < 15; i++) tick(1'b1, '0, cur_sel, 1'b1);
      n_total++;
      if ({out_valid, out_sum, out_max, out_count, out_partial} !== {1'b1, 20'd7, 16'd7, 5'd16, 1'b0}) begin
         $display("FAIL partial_next got v=%0b sum=%0d max=%0d cnt=%0d p=%0b required v=1 sum=7 max=7 cnt=16 p=0",
                  out_valid, out_sum, out_max, out_count, out_partial);
      end else n_pass++;
      tick(1'b0, '0, cur_sel, 1'b1);
   endtask

   task automatic test_gaps;
      int nval = 0;
      int nres = 0;
      int guard = 0;
      while (nval < 40 && guard < 1000) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         tick(v, 16'h0010, cur_sel, 1'b1);
         if (v) nval++;
         guard++;
         if (out_valid === 1'b1) begin
            nres++;
            n_total++;
            if ({out_sum, out_count, out_partial} !== {20'h00100, 5'd16, 1'b0}) begin
               $display("FAIL gaps_result got sum=%h cnt=%0d p=%0b required sum=00100 cnt=16 p=0",
                        out_sum, out_count, out_partial);
            end else n_pass++;
         end
      end
      n_total++;
      if (nres !== 2 || nval !== 40) begin
         $display("FAIL gaps_count got results=%0d samples=%0d required results=2 samples=40", nres, nval);
      end else n_pass++;
   endtask

   task automatic test_flush_idle;
      cur_sel = ~cur_sel;
      tick(1'b0, '0, cur_sel, 1'b1);
      n_total++;
      if ({out_valid, out_sum, out_max, out_count, out_partial} !== {1'b1, 20'h00080, 16'h0010, 5'd8, 1'b1}) begin
         $display("FAIL flush_idle got v=%0b sum=%h max=%h cnt=%0d p=%0b required v=1 sum=00080 max=0010 cnt=8 p=1",
                  out_valid, out_sum, out_max, out_count, out_partial);
      end else n_pass++;
      cur_sel = ~cur_sel;
      tick(1'b0, '0, cur_sel, 1'b1);
      n_total++;
      if (out_valid !== 1'b0) begin
         $display("FAIL flush_empty got out_valid=%0b required 0", out_valid);
      end else n_pass++;
   endtask

   task automatic test_overrun;
      for (int i = 0; i < 32; i++) begin
         tick(1'b1, DW'($urandom), cur_sel, 1'b0);
         n_total++;
         if ({out_valid, overrun} !== {exp_q.size() != 0, e_ovr}) begin
            $display("FAIL ovr_state i=%0d got v=%0b ovr=%0b required v=%0b ovr=%0b",
                     i, out_valid, overrun, exp_q.size() != 0, e_ovr);
         end else n_pass++;
      end
      n_total++;
      if (exp_q.size() == 0 || {out_valid, overrun, out_sum, out_max, out_count} !==
          {2'b11, exp_q[0].sum, exp_q[0].mx, exp_q[0].cnt}) begin
         $display("FAIL ovr_hold got v=%0b ovr=%0b sum=%h max=%h cnt=%0d required v=1 ovr=1 second window",
                  out_valid, overrun, out_sum, out_max, out_count);
      end else n_pass++;
      tick(1'b0, '0, cur_sel, 1'b1);
      n_total++;
      if ({out_valid, overrun} !== 2'b01) begin
         $display("FAIL ovr_drain got v=%0b ovr=%0b required v=0 ovr=1", out_valid, overrun);
      end else n_pass++;
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 9; i++) tick(1'b1, 16'h0100, cur_sel, 1'b1);
      test_reset(1'b1);
      for (int i = 0; i < 17; i++) begin
         tick((i < 16), 16'h0003, cur_sel, 1'b1);
         n_total++;
         if (out_valid !== (exp_q.size() != 0)) begin
            $display("FAIL rstmid_valid i=%0d got %0b required %0b", i, out_valid, exp_q.size() != 0);
         end else n_pass++;
         if (i == 15) begin
            n_total++;
            if ({out_valid, out_sum, out_count, out_partial} !== {1'b1, 20'd48, 5'd16, 1'b0}) begin
               $display("FAIL rstmid_result got v=%0b sum=%0d cnt=%0d p=%0b required v=1 sum=48 cnt=16 p=0",
                        out_valid, out_sum, out_count, out_partial);
            end else n_pass++;
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) cur_sel = ~cur_sel;
         tick(1'($urandom_range(0, 1)), DW'($urandom), cur_sel, ($urandom_range(0, 9) < 7));
         n_total++;
         if ({out_valid, overrun} !== {exp_q.size() != 0, e_ovr}) begin
            $display("FAIL rand_state i=%0d got v=%0b ovr=%0b required v=%0b ovr=%0b",
                     i, out_valid, overrun, exp_q.size() != 0, e_ovr);
         end else n_pass++;
         if (exp_q.size() != 0) begin
            n_total++;
            if ({out_sum, out_max, out_count, out_partial} !==
                {exp_q[0].sum, exp_q[0].mx, exp_q[0].cnt, exp_q[0].part}) begin
               $display("FAIL rand_data i=%0d got sum=%h max=%h cnt=%0d p=%0b required sum=%h max=%h cnt=%0d p=%0b",
                        i, out_sum, out_max, out_count, out_partial,
                        exp_q[0].sum, exp_q[0].mx, exp_q[0].cnt, exp_q[0].part);
            end else n_pass++;
         end
      end
   endtask

   initial begin
      msel    = 1'b0;
      e_ovr   = 1'b0;
      cur_sel = 1'b0;
      #3;
      test_reset(1'b0);
      test_const;
      test_extremes;
      test_partial;
      test_gaps;
      test_flush_idle;
      test_overrun;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
